// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//   Controller for a NUM_LAYERS-deep network of layers: input (index 0),
//   hidden layers, and softmax output (index NUM_LAYERS-1). A pass always
//   runs the forward step. In training mode it then runs the backward
//   (delta) step and the weight-update step.
//
//   Ports
//     clock                  rising-edge clock
//     reset                  synchronous, active-high
//     start                  begin one pass; sampled only in IDLE
//     train                  sampled with start: 1 = fwd+bwd+update, 0 = fwd only
//     busy                   high in FORWARD / BACKWARD / UPDATE
//     done                   one-cycle pulse in DONE
//     enable_layers          one-hot enable of the active layer, 0 when idle
//     active_layer           index of the enabled layer, 0 when idle
//     layer_state            00 hold, 01 forward, 10 backward, 11 update
//     weight_memory_address  weight index swept during UPDATE, 0 otherwise
//     train_count            number of completed training passes (wraps)
// -----------------------------------------------------------------------------
module layer_sequencer #(
   parameter int NUM_LAYERS      = 4,
   parameter int MAX_NUM_NEURONS = 4,
   parameter int LAYER_LATENCY   = 2,
   parameter int CNT_W           = 16
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               train,
   output logic                               busy,
   output logic                               done,
   output logic [NUM_LAYERS-1:0]              enable_layers,
   output logic [$clog2(NUM_LAYERS)-1:0]      active_layer,
   output logic [1:0]                         layer_state,
   output logic [$clog2(MAX_NUM_NEURONS)-1:0] weight_memory_address,
   output logic [CNT_W-1:0]                   train_count
);

   localparam int LW = $clog2(NUM_LAYERS);
   localparam int AW = $clog2(MAX_NUM_NEURONS);
   // A latency of 1 still needs a 1-bit counter that simply stays at 0.
   localparam int CW = (LAYER_LATENCY > 1) ? $clog2(LAYER_LATENCY) : 1;

   localparam logic [LW-1:0]         LAST_LAYER   = LW'(NUM_LAYERS - 1);
   localparam logic [LW-1:0]         FIRST_HIDDEN = LW'(1);
   localparam logic [AW-1:0]         LAST_ADDR    = AW'(MAX_NUM_NEURONS - 1);
   localparam logic [CW-1:0]         LAST_CNT     = CW'(LAYER_LATENCY - 1);
   localparam logic [NUM_LAYERS-1:0] LAST_EN      = {1'b1, {(NUM_LAYERS-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_FORWARD,
      S_BACKWARD,
      S_UPDATE,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      LS_HOLD     = 2'b00,
      LS_FORWARD  = 2'b01,
      LS_BACKWARD = 2'b10,
      LS_UPDATE   = 2'b11
   } layer_state_t;

   state_t        state;
   logic          train_q;   // pass type captured at the start-accept edge
   logic [CW-1:0] cnt;       // cycles spent on the current layer step

   // Every output is a register updated together with the state, so the
   // layer instances see glitch-free enables. The enable vector is shifted
   // in step with active_layer, which keeps it equal to 1<<active_layer.
   // NOTE: all state here is written with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state                 <= S_IDLE;
         train_q               <= 1'b0;
         cnt                   <= '0;
         busy                  <= 1'b0;
         done                  <= 1'b0;
         enable_layers         <= '0;
         active_layer          <= '0;
         layer_state           <= LS_HOLD;
         weight_memory_address <= '0;
         train_count           <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state         <= S_FORWARD;
                  train_q       <= train;
                  cnt           <= '0;
                  busy          <= 1'b1;
                  enable_layers <= {{(NUM_LAYERS-1){1'b0}}, 1'b1};
                  active_layer  <= '0;
                  layer_state   <= LS_FORWARD;
               end
            end

            S_FORWARD: begin
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (active_layer == LAST_LAYER) begin
                     if (train_q) begin
                        // Backward starts on the output layer, already enabled.
                        state       <= S_BACKWARD;
                        layer_state <= LS_BACKWARD;
                     end else begin
                        state         <= S_DONE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        enable_layers <= '0;
                        active_layer  <= '0;
                        layer_state   <= LS_HOLD;
                     end
                  end else begin
                     active_layer  <= active_layer + LW'(1);
                     enable_layers <= enable_layers << 1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            S_BACKWARD: begin
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (active_layer == FIRST_HIDDEN) begin
                     // The input layer has no deltas; jump back to the top.
                     state                 <= S_UPDATE;
                     layer_state           <= LS_UPDATE;
                     active_layer          <= LAST_LAYER;
                     enable_layers         <= LAST_EN;
                     weight_memory_address <= '0;
                  end else begin
                     active_layer  <= active_layer - LW'(1);
                     enable_layers <= enable_layers >> 1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            S_UPDATE: begin
               if (weight_memory_address == LAST_ADDR) begin
                  weight_memory_address <= '0;
                  if (active_layer == FIRST_HIDDEN) begin
                     // Only training passes reach here, so count unconditionally.
                     state         <= S_DONE;
                     busy          <= 1'b0;
                     done          <= 1'b1;
                     enable_layers <= '0;
                     active_layer  <= '0;
                     layer_state   <= LS_HOLD;
                     train_count   <= train_count + CNT_W'(1);
                  end else begin
                     active_layer  <= active_layer - LW'(1);
                     enable_layers <= enable_layers >> 1;
                  end
               end else begin
                  weight_memory_address <= weight_memory_address + AW'(1);
               end
            end

            S_DONE: begin
               // start is deliberately not looked at here.
               state <= S_IDLE;
               done  <= 1'b0;
            end

            default: begin
               state                 <= S_IDLE;
               cnt                   <= '0;
               busy                  <= 1'b0;
               done                  <= 1'b0;
               enable_layers         <= '0;
               active_layer          <= '0;
               layer_state           <= LS_HOLD;
               weight_memory_address <= '0;
            end
         endcase
      end
   end

endmodule
